// File: rtl/mul_unit_if.sv
// ---------------------------------------------------------------------------
// mul_unit_if
// Request/response bundle between the EX stage and the iterative multiplier.
//   mul_valid  : EX holds this high while a MUL/MULH/MULW sits in EX
//   mul_op     : 00 MUL, 01 MULH, 10 MULW, 11 reserved (behaves as MUL)
//   mul_op1    : multiplicand (forwarded rs1)
//   mul_op2    : multiplier (forwarded rs2)
//   flush      : pipeline flush, kills any in-flight operation
//   ex_allowin : EX->MEM register updates this cycle (consumes the result)
//   mul_ready  : result valid (registered)
//   mul_result : 128-bit signed product (registered)
// Modports: master = EX stage side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface mul_unit_if;
    logic         mul_valid;
    logic [1:0]   mul_op;
    logic [63:0]  mul_op1;
    logic [63:0]  mul_op2;
    logic         flush;
    logic         ex_allowin;
    logic         mul_ready;
    logic [127:0] mul_result;

    modport master (
        output mul_valid, mul_op, mul_op1, mul_op2, flush, ex_allowin,
        input  mul_ready, mul_result
    );

    modport slave (
        input  mul_valid, mul_op, mul_op1, mul_op2, flush, ex_allowin,
        output mul_ready, mul_result
    );
endinterface

// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
// Iterative radix-4 signed multiplier serving the EX stage.
// Operands are converted to 64-bit unsigned magnitudes on capture; each CALC
// cycle adds |a| * (next 2-bit digit of |b|) into a 128-bit accumulator, and
// the sign is applied once on the final iteration.
//
// Ports:
//   clk    : core clock
//   rst    : asynchronous, active-low reset
//   mul_if : mul_unit_if.slave (request, operands, flush, ex_allowin in;
//            mul_ready, mul_result out, both registered)
//
// Build option:
//   MUL_WORD_FAST_EN : when defined, MULW runs 16 iterations instead of 32
//                      (its magnitude never exceeds 2^31). Results are the
//                      same in both builds; only MULW latency differs.
// ---------------------------------------------------------------------------
module mul_unit (
    input  logic         clk,
    input  logic         rst,
    mul_unit_if.slave    mul_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULW = 2'b10;

    // Two's-complement magnitude; INT64_MIN maps to unsigned 2^63.
    function automatic logic [63:0] f_abs64(input logic [63:0] v);
        f_abs64 = v[63] ? (~v + 64'd1) : v;
    endfunction

    // 128-bit two's-complement negation.
    function automatic logic [127:0] f_neg128(input logic [127:0] v);
        f_neg128 = ~v + 128'd1;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_mcand;
    logic [63:0]    r_mplier;
    logic [127:0]   r_acc;
    logic [127:0]   r_result;
    logic [4:0]     r_cnt;
    logic           r_neg;
    logic           r_ready;

    logic [63:0]    w_a;
    logic [63:0]    w_b;
    logic [4:0]     w_cnt_init;
    logic [127:0]   w_pp;
    logic [127:0]   w_acc_sum;
    logic           w_last;
    logic           w_capture;
    logic           w_step;
    logic           w_finish;

    // Operand selection: MULW sign-extends the low words to 64 bits.
    always_comb begin
        w_a = mul_if.mul_op1;
        w_b = mul_if.mul_op2;
        if (mul_if.mul_op == OP_MULW) begin
            w_a = {{32{mul_if.mul_op1[31]}}, mul_if.mul_op1[31:0]};
            w_b = {{32{mul_if.mul_op2[31]}}, mul_if.mul_op2[31:0]};
        end else begin
            w_a = mul_if.mul_op1;
            w_b = mul_if.mul_op2;
        end
    end

    // Iteration count: counter runs from N-1 down to 0.
    always_comb begin
        w_cnt_init = 5'd31;
`ifdef MUL_WORD_FAST_EN
        if (mul_if.mul_op == OP_MULW) begin
            w_cnt_init = 5'd15;
        end else begin
            w_cnt_init = 5'd31;
        end
`else
        w_cnt_init = 5'd31;
`endif
    end

    // Partial product for the current radix-4 digit; r_mcand already carries
    // the 2*i shift because it moves left by two every iteration.
    always_comb begin
        w_pp = 128'd0;
        case (r_mplier[1:0])
            2'd0:    w_pp = 128'd0;
            2'd1:    w_pp = r_mcand;
            2'd2:    w_pp = {r_mcand[126:0], 1'b0};
            2'd3:    w_pp = r_mcand + {r_mcand[126:0], 1'b0};
            default: w_pp = 128'd0;
        endcase
    end

    assign w_acc_sum = r_acc + w_pp;
    assign w_last    = (r_cnt == 5'd0);

    // Next-state logic; flush and a dropped request win over capture and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mul_if.mul_valid && !mul_if.flush) begin
                    w_state_nxt = S_CALC;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (mul_if.flush || !mul_if.mul_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_step      = 1'b1;
                    w_finish    = 1'b1;
                end else begin
                    w_state_nxt = S_CALC;
                    w_step      = 1'b1;
                end
            end
            S_DONE: begin
                if (mul_if.flush || !mul_if.mul_valid || mul_if.ex_allowin) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand capture and one radix-4 step per CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= 128'd0;
            r_mplier <= 64'd0;
            r_acc    <= 128'd0;
            r_cnt    <= 5'd0;
            r_neg    <= 1'b0;
        end else if (w_capture) begin
            r_mcand  <= {64'd0, f_abs64(w_a)};
            r_mplier <= f_abs64(w_b);
            r_acc    <= 128'd0;
            r_cnt    <= w_cnt_init;
            r_neg    <= w_a[63] ^ w_b[63];
        end else if (w_step) begin
            r_mcand  <= {r_mcand[125:0], 2'b00};
            r_mplier <= {2'b00, r_mplier[63:2]};
            r_acc    <= w_acc_sum;
            r_cnt    <= w_last ? 5'd0 : (r_cnt - 5'd1);
        end else begin
            r_mcand  <= r_mcand;
            r_mplier <= r_mplier;
            r_acc    <= r_acc;
            r_cnt    <= r_cnt;
        end
    end

    // Registered outputs: result written only on completion, ready mirrors DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= 128'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_finish) begin
                r_result <= r_neg ? f_neg128(w_acc_sum) : w_acc_sum;
            end else begin
                r_result <= r_result;
            end
            r_ready <= (w_state_nxt == S_DONE);
        end
    end

    assign mul_if.mul_ready  = r_ready;
    assign mul_if.mul_result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_unit
// Self-checking bench for mul_unit. Expected products come from plain signed
// 128-bit arithmetic on the sign-extended operands. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mul_unit;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mul_unit_if u_if ();

    mul_unit u_dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference product: sign-extend to 128 bits and multiply.
    function automatic logic [127:0] model(input logic [1:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        if (op == 2'b10) begin
            sa = {{96{a[31]}}, a[31:0]};
            sb = {{96{b[31]}}, b[31:0]};
        end else begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
        end
        model = sa * sb;
    endfunction

    // Falling edges from driving the request until ready is first seen.
    function automatic int exp_lat(input logic [1:0] op);
`ifdef MUL_WORD_FAST_EN
        if (op == 2'b10) return 17;
`endif
        return 33;
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 5))
            0:       return 64'h8000_0000_0000_0000;
            1:       return 64'd0;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op (called at a falling edge), check latency, result, hold and release.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input int hold, output logic [127:0] res);
        logic [127:0] exp_res;
        int lat;
        exp_res = model(op, a, b);
        u_if.mul_valid  = 1'b1;
        u_if.mul_op     = op;
        u_if.mul_op1    = a;
        u_if.mul_op2    = b;
        u_if.flush      = 1'b0;
        u_if.ex_allowin = 1'b0;
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (u_if.mul_ready) begin
                lat = k;
                break;
            end
            // operands after capture must be ignored
            if (k == 1) begin
                u_if.mul_op1 = {$urandom, $urandom};
                u_if.mul_op2 = {$urandom, $urandom};
            end
        end
        check_val({tag, "_lat"}, 128'(lat), 128'(exp_lat(op)));
        res = u_if.mul_result;
        check_val({tag, "_res"}, res, exp_res);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val({tag, "_hold_rdy"}, {127'd0, u_if.mul_ready}, 128'd1);
            check_val({tag, "_hold_res"}, u_if.mul_result, exp_res);
        end
        u_if.ex_allowin = 1'b1;
        @(negedge clk);
        check_val({tag, "_drop"}, {127'd0, u_if.mul_ready}, 128'd0);
        u_if.ex_allowin = 1'b0;
        u_if.mul_valid  = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] prev;
        int rdy_seen;
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        u_if.mul_valid  = 1'b0;
        u_if.mul_op     = 2'b00;
        u_if.mul_op1    = 64'd0;
        u_if.mul_op2    = 64'd0;
        u_if.flush      = 1'b0;
        u_if.ex_allowin = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_rdy", {127'd0, u_if.mul_ready}, 128'd0);
        check_val("rst_res", u_if.mul_result, 128'd0);
        rst = 1'b1;
        @(negedge clk);

        // MUL 3 x -5
        run_op("mul3x-5", 2'b00, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, res);
        check_val("mul3x-5_lo", {64'd0, res[63:0]}, {64'd0, 64'hFFFF_FFFF_FFFF_FFF1});
        check_val("mul3x-5_hi", {64'd0, res[127:64]}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});

        // MULH INT64_MIN squared
        run_op("mulh_min2", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, res);
        check_val("mulh_min2_hi", {64'd0, res[127:64]}, {64'd0, 64'h4000_0000_0000_0000});
        check_val("mulh_min2_lo", {64'd0, res[63:0]}, 128'd0);

        // MULW
        run_op("mulw", 2'b10, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 0, res);
        check_val("mulw_lo", {96'd0, res[31:0]}, {96'd0, 32'hFFFF_FFFE});
        check_val("mulw_hi", {32'd0, res[127:32]}, 128'd0);

        // DONE hold for 5 cycles, then back-to-back 7 x 6 captured in the IDLE cycle
        run_op("hold5", 2'b00, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_1234_5678, 5, res);
        run_op("b2b", 2'b00, 64'd7, 64'd6, 0, res);
        check_val("b2b_42", res, 128'd42);

        // Flush mid-CALC: no ready, result unchanged, then a new op at full latency
        prev = res;
        u_if.mul_valid = 1'b1;
        u_if.mul_op    = 2'b00;
        u_if.mul_op1   = pick64();
        u_if.mul_op2   = pick64();
        rdy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (u_if.mul_ready) rdy_seen++;
        end
        u_if.flush = 1'b1;
        @(negedge clk);
        u_if.flush = 1'b0;
        if (u_if.mul_ready) rdy_seen++;
        check_val("flush_rdy", 128'(rdy_seen), 128'd0);
        check_val("flush_res", u_if.mul_result, prev);
        run_op("post_flush", 2'b00, pick64(), pick64(), 0, res);

        // Flush beats capture in IDLE: the op only starts once flush drops
        u_if.mul_valid = 1'b1;
        u_if.flush     = 1'b1;
        repeat (3) @(negedge clk);
        run_op("flush_idle", 2'b01, pick64(), pick64(), 1, res);

        // Request withdrawn mid-CALC cancels the op
        prev = res;
        u_if.mul_valid = 1'b1;
        u_if.mul_op1   = pick64();
        u_if.mul_op2   = pick64();
        repeat (5) @(negedge clk);
        u_if.mul_valid = 1'b0;
        repeat (40) @(negedge clk);
        check_val("cancel_rdy", {127'd0, u_if.mul_ready}, 128'd0);
        check_val("cancel_res", u_if.mul_result, prev);

        // Randomized ops, mostly back-to-back
        for (int i = 0; i < 20; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), pick64(), pick64(),
                   $urandom_range(0, 2), res);
        end

        // Asynchronous reset mid-CALC
        run_op("pre_rst", 2'b00, 64'd11, 64'd13, 0, res);
        u_if.mul_valid = 1'b1;
        u_if.mul_op1   = pick64();
        u_if.mul_op2   = pick64();
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_rdy", {127'd0, u_if.mul_ready}, 128'd0);
        check_val("arst_res", u_if.mul_result, 128'd0);
        u_if.mul_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op("post_rst", 2'b10, pick64(), pick64(), 0, res);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
